// File: rtl/spi_device.sv
// spi_device: SPI mode-0 target. The raw SCK/CS_n/MOSI pins are synchronized into
// the clk domain. The block shifts in received bytes MSB-first and shifts out a
// transmit byte on MISO from a single pending buffer.
// Ports:
//   clk, reset              system clock, synchronous active-high reset
//   spi_clk_in/cs_n_in/mosi_in   raw asynchronous SPI pins
//   spi_miso_out            registered MISO
//   spi_cs                  synchronized select (1 = idle)
//   spi_rx_data/rx_bit      receive shift register / index of last received bit
//   spi_rx_bit_strobe/rx_strobe/rx_cmd   per-bit, per-byte, first-byte pulses
//   spi_tx_data/tx_strobe   next transmit byte and its load strobe
//   tx_underrun             boundary reload of a stale (not refreshed) byte
module spi_device #(
   parameter int unsigned SYNC_STAGES = 2
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       spi_clk_in,
   input  logic       spi_cs_n_in,
   input  logic       spi_mosi_in,
   output logic       spi_miso_out,
   output logic       spi_cs,
   output logic [7:0] spi_rx_data,
   output logic [2:0] spi_rx_bit,
   output logic       spi_rx_bit_strobe,
   output logic       spi_rx_strobe,
   output logic       spi_rx_cmd,
   input  logic [7:0] spi_tx_data,
   input  logic       spi_tx_strobe,
   output logic       tx_underrun
);

   localparam int unsigned BYTE_W = 8;
   localparam int unsigned CNT_W  = 3;

   // Synchronizers plus one history flop for the edge-detected inputs.
   logic [SYNC_STAGES-1:0] sck_sync_q, cs_sync_q, mosi_sync_q;
   logic                   sck_hist_q, cs_hist_q;

   always_ff @(posedge clk) begin
      if (reset) begin
         sck_sync_q  <= '0;
         cs_sync_q   <= '1;
         mosi_sync_q <= '0;
         sck_hist_q  <= 1'b0;
         cs_hist_q   <= 1'b1;
      end else begin
         sck_sync_q  <= {sck_sync_q[SYNC_STAGES-2:0], spi_clk_in};
         cs_sync_q   <= {cs_sync_q[SYNC_STAGES-2:0], spi_cs_n_in};
         mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], spi_mosi_in};
         sck_hist_q  <= sck_sync_q[SYNC_STAGES-1];
         cs_hist_q   <= cs_sync_q[SYNC_STAGES-1];
      end
   end

   // Edge decode from the last synchronizer stage and the history flop.
   logic sck_rise_c, sck_fall_c, cs_assert_c, cs_deassert_c;
   assign sck_rise_c    =  sck_sync_q[SYNC_STAGES-1] & ~sck_hist_q;
   assign sck_fall_c    = ~sck_sync_q[SYNC_STAGES-1] &  sck_hist_q;
   assign cs_assert_c   = ~cs_sync_q[SYNC_STAGES-1]  &  cs_hist_q;
   assign cs_deassert_c =  cs_sync_q[SYNC_STAGES-1]  & ~cs_hist_q;

   // Registered events, with MOSI captured alongside its SCK rise.
   logic ev_rise_q, ev_fall_q, ev_assert_q, ev_deassert_q, ev_mosi_q;

   always_ff @(posedge clk) begin
      if (reset) begin
         ev_rise_q     <= 1'b0;
         ev_fall_q     <= 1'b0;
         ev_assert_q   <= 1'b0;
         ev_deassert_q <= 1'b0;
         ev_mosi_q     <= 1'b0;
      end else begin
         ev_rise_q     <= sck_rise_c;
         ev_fall_q     <= sck_fall_c;
         ev_assert_q   <= cs_assert_c;
         ev_deassert_q <= cs_deassert_c;
         ev_mosi_q     <= mosi_sync_q[SYNC_STAGES-1];
      end
   end

   // Transaction state.
   logic              cs_q, cs_d;
   logic              miso_q, miso_d;
   logic [BYTE_W-1:0] rx_data_q, rx_data_d;
   logic [CNT_W-1:0]  rx_bit_q, rx_bit_d;
   logic              bit_strb_q, bit_strb_d;
   logic              rx_strb_q, rx_strb_d;
   logic              rx_cmd_q, rx_cmd_d;
   logic              underrun_q, underrun_d;
   logic [BYTE_W-1:0] tx_buf_q, tx_buf_d;
   logic              fresh_q, fresh_d;
   logic [BYTE_W-1:0] tx_sr_q, tx_sr_d;
   logic [CNT_W-1:0]  bit_cnt_q, bit_cnt_d;
   logic              first_q, first_d;      // next completed byte is the command byte
   logic              byte_done_q, byte_done_d;  // 8th rise seen, next fall reloads
   logic              late_q, late_d;        // window for a late tx load
   logic [BYTE_W-1:0] load_byte_c;
   logic [CNT_W-1:0]  cnt_c;

   // Next-state logic for rx shifting, tx loading and select handling.
   always_comb begin
      cs_d        = cs_q;
      miso_d      = miso_q;
      rx_data_d   = rx_data_q;
      rx_bit_d    = rx_bit_q;
      bit_strb_d  = 1'b0;
      rx_strb_d   = 1'b0;
      rx_cmd_d    = 1'b0;
      underrun_d  = 1'b0;
      tx_buf_d    = tx_buf_q;
      fresh_d     = fresh_q;
      tx_sr_d     = tx_sr_q;
      bit_cnt_d   = bit_cnt_q;
      first_d     = first_q;
      byte_done_d = byte_done_q;
      late_d      = late_q;

      // A strobe coinciding with a load is consumed directly.
      load_byte_c = spi_tx_strobe ? spi_tx_data : tx_buf_q;
      cnt_c       = ev_assert_q ? CNT_W'(0) : bit_cnt_q;

      if (spi_tx_strobe) begin
         tx_buf_d = spi_tx_data;
         fresh_d  = 1'b1;
      end

      if (ev_deassert_q) begin
         cs_d        = 1'b1;
         miso_d      = 1'b1;
         bit_cnt_d   = '0;
         byte_done_d = 1'b0;
         late_d      = 1'b0;
      end else begin
         if (ev_assert_q) begin
            cs_d        = 1'b0;
            tx_sr_d     = load_byte_c;
            miso_d      = load_byte_c[BYTE_W-1];
            fresh_d     = 1'b0;
            bit_cnt_d   = '0;
            first_d     = 1'b1;
            byte_done_d = 1'b0;
            late_d      = 1'b0;
         end else if (!cs_q && ev_fall_q && byte_done_q) begin
            tx_sr_d     = load_byte_c;
            miso_d      = load_byte_c[BYTE_W-1];
            underrun_d  = ~fresh_q & ~spi_tx_strobe;
            fresh_d     = 1'b0;
            byte_done_d = 1'b0;
            late_d      = 1'b1;
         end else if (!cs_q && ev_fall_q && bit_cnt_q != '0) begin
            tx_sr_d = {tx_sr_q[BYTE_W-2:0], 1'b1};
            miso_d  = tx_sr_q[BYTE_W-2];
         end else if (spi_tx_strobe && late_q && !ev_rise_q) begin
            // Late byte replaces the stale one before it is shifted out.
            tx_sr_d = spi_tx_data;
            miso_d  = spi_tx_data[BYTE_W-1];
            fresh_d = 1'b0;
         end

         // Select assert wins over a same-cycle rise, so the rise still counts.
         if (ev_rise_q && (ev_assert_q || !cs_q)) begin
            rx_data_d  = {rx_data_q[BYTE_W-2:0], ev_mosi_q};
            rx_bit_d   = cnt_c;
            bit_strb_d = 1'b1;
            bit_cnt_d  = cnt_c + CNT_W'(1);
            late_d     = 1'b0;
            if (cnt_c == CNT_W'(7)) begin
               rx_strb_d   = 1'b1;
               rx_cmd_d    = first_q | ev_assert_q;
               first_d     = 1'b0;
               byte_done_d = 1'b1;
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         cs_q        <= 1'b1;
         miso_q      <= 1'b1;
         rx_data_q   <= '0;
         rx_bit_q    <= '0;
         bit_strb_q  <= 1'b0;
         rx_strb_q   <= 1'b0;
         rx_cmd_q    <= 1'b0;
         underrun_q  <= 1'b0;
         tx_buf_q    <= 8'hFF;
         fresh_q     <= 1'b0;
         tx_sr_q     <= 8'hFF;
         bit_cnt_q   <= '0;
         first_q     <= 1'b0;
         byte_done_q <= 1'b0;
         late_q      <= 1'b0;
      end else begin
         cs_q        <= cs_d;
         miso_q      <= miso_d;
         rx_data_q   <= rx_data_d;
         rx_bit_q    <= rx_bit_d;
         bit_strb_q  <= bit_strb_d;
         rx_strb_q   <= rx_strb_d;
         rx_cmd_q    <= rx_cmd_d;
         underrun_q  <= underrun_d;
         tx_buf_q    <= tx_buf_d;
         fresh_q     <= fresh_d;
         tx_sr_q     <= tx_sr_d;
         bit_cnt_q   <= bit_cnt_d;
         first_q     <= first_d;
         byte_done_q <= byte_done_d;
         late_q      <= late_d;
      end
   end

   assign spi_cs            = cs_q;
   assign spi_miso_out      = miso_q;
   assign spi_rx_data       = rx_data_q;
   assign spi_rx_bit        = rx_bit_q;
   assign spi_rx_bit_strobe = bit_strb_q;
   assign spi_rx_strobe     = rx_strb_q;
   assign spi_rx_cmd        = rx_cmd_q;
   assign tx_underrun       = underrun_q;

endmodule
